// File: rtl/fpu_ss_pkg.sv
`default_nettype none
// ============================================================================
// Module : fpu_ss_pkg
// Shared FPU-subsystem types: writeback source IDs and FP register addresses.
// Rev    : 1.0
// ============================================================================
package fpu_ss_pkg;

    typedef enum logic [0:0] {
        WbFpu = 1'b0,
        WbLsu = 1'b1
    } wb_src_e;

    localparam int unsigned FPR_ADDR_W = 5;
    typedef logic [FPR_ADDR_W-1:0] fpr_addr_t;

    // Width needed to count 0..num_wb simultaneous writebacks to one register.
    function automatic int unsigned dec_width(input int unsigned num_wb);
        return (num_wb > 0) ? $clog2(num_wb + 1) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_ss_pending_cnt.sv
`default_nettype none
// ============================================================================
// Module : fpu_ss_pending_cnt
// Pending-write counter for one FP register; clamps and flags under/overflow.
// Rev    : 1.0
// ============================================================================
module fpu_ss_pending_cnt #(
    parameter int unsigned CNT_WIDTH = 2,
    parameter int unsigned DEC_WIDTH = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 inc_i,
    input  logic [DEC_WIDTH-1:0] dec_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 busy_o,
    output logic                 sat_o,
    output logic                 underflow_o,
    output logic                 overflow_o
);

    localparam int unsigned c_sum_w = ((CNT_WIDTH > DEC_WIDTH) ? CNT_WIDTH : DEC_WIDTH) + 1;
    localparam logic [c_sum_w-1:0] c_max = c_sum_w'((1 << CNT_WIDTH) - 1);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic [c_sum_w-1:0]   w_sum;
    logic [c_sum_w-1:0]   w_dec;
    logic [c_sum_w-1:0]   w_net;

    // Wide intermediate so increment and decrement net out before clamping.
    always_comb begin
        w_sum       = c_sum_w'(cnt_q) + c_sum_w'(inc_i);
        w_dec       = c_sum_w'(dec_i);
        w_net       = w_sum - w_dec;
        underflow_o = (w_dec > w_sum);
        overflow_o  = 1'b0;
        cnt_d       = CNT_WIDTH'(w_net);
        if (underflow_o) begin
            cnt_d = '0;
        end else if (w_net > c_max) begin
            overflow_o = 1'b1;
            cnt_d      = '1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign busy_o = |cnt_q;
    assign sat_o  = &cnt_q;

endmodule
`default_nettype wire

// File: rtl/fpu_ss_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module : fpu_ss_hazard_unit
// Operand-hazard, forwarding and commit tracker gating issue of the head instr.
// Optional: FPU_SS_HAZARD_PERF_CNT_EN enables the stalled-cycle counter.
// Rev    : 1.0
// ============================================================================
module fpu_ss_hazard_unit
    import fpu_ss_pkg::*;
#(
    parameter  int unsigned NUM_REGS     = 32,
    parameter  int unsigned NUM_OPERANDS = 3,
    parameter  int unsigned NUM_WB       = 2,
    parameter  int unsigned ID_WIDTH     = 4,
    parameter  int unsigned CNT_WIDTH    = 2,
    parameter  int unsigned ALLOW_WAW    = 0,
    parameter  int unsigned FORWARDING   = 1,
    localparam int unsigned AW           = $clog2(NUM_REGS)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           issue_valid_i,
    output logic                           issue_ready_o,
    input  logic [ID_WIDTH-1:0]            issue_id_i,
    input  logic [NUM_OPERANDS*AW-1:0]     rs_addr_i,
    input  logic [NUM_OPERANDS-1:0]        rs_used_i,
    input  logic [AW-1:0]                  rd_addr_i,
    input  logic                           rd_we_i,
    input  logic                           commit_valid_i,
    input  logic [ID_WIDTH-1:0]            commit_id_i,
    input  logic                           commit_kill_i,
    input  logic                           retire_valid_i,
    input  logic [ID_WIDTH-1:0]            retire_id_i,
    input  logic [NUM_WB-1:0]              wb_valid_i,
    input  logic [NUM_WB*AW-1:0]           wb_addr_i,
    output logic [NUM_OPERANDS*NUM_WB-1:0] fwd_sel_o,
    output logic                           stall_raw_o,
    output logic                           stall_commit_o,
    output logic                           err_o,
    output logic [31:0]                    perf_stall_cnt_o
);

    localparam int unsigned c_dec_w   = dec_width(NUM_WB);
    localparam int unsigned c_num_ids = 2 ** ID_WIDTH;

    logic [CNT_WIDTH-1:0]           w_cnt   [NUM_REGS];
    logic [c_dec_w-1:0]             w_dec   [NUM_REGS];
    logic [NUM_REGS-1:0]            w_busy;
    logic [NUM_REGS-1:0]            w_sat;
    logic [NUM_REGS-1:0]            w_under;
    logic [NUM_REGS-1:0]            w_over;
    logic [NUM_REGS-1:0]            w_inc;
    logic [NUM_WB-1:0]              w_match [NUM_OPERANDS];
    logic [NUM_OPERANDS-1:0]        w_raw_op;
    logic [NUM_OPERANDS*NUM_WB-1:0] w_fwd_sel;
    logic                           w_commit_set;
    logic                           w_committed_ok;
    logic                           w_raw;
    logic                           w_waw;
    logic                           w_sat_hit;
    logic [c_num_ids-1:0]           commit_q;
    logic [c_num_ids-1:0]           commit_d;
    logic                           err_q;

    always_comb begin
        for (int k = 0; k < NUM_OPERANDS; k++) begin
            for (int w = 0; w < NUM_WB; w++) begin
                w_match[k][w] = wb_valid_i[w] & rs_used_i[k]
                              & (wb_addr_i[w*AW +: AW] == rs_addr_i[k*AW +: AW]);
            end
        end
    end

    // Descending scan so the lowest-index matching source wins the select.
    always_comb begin
        w_fwd_sel = '0;
        w_raw_op  = '0;
        for (int k = 0; k < NUM_OPERANDS; k++) begin
            if (FORWARDING != 0) begin
                for (int w = NUM_WB - 1; w >= 0; w--) begin
                    if (w_match[k][w]) begin
                        w_fwd_sel[k*NUM_WB +: NUM_WB] = NUM_WB'(1) << w;
                    end
                end
            end
            w_raw_op[k] = rs_used_i[k] & w_busy[rs_addr_i[k*AW +: AW]]
                        & ~((FORWARDING != 0)
                            & (w_cnt[rs_addr_i[k*AW +: AW]] == CNT_WIDTH'(1))
                            & (|w_match[k]));
        end
    end

    always_comb begin
        w_commit_set   = commit_valid_i & ~commit_kill_i;
        w_committed_ok = commit_q[issue_id_i] | (w_commit_set & (commit_id_i == issue_id_i));
        w_raw          = |w_raw_op;
        w_waw          = rd_we_i & w_busy[rd_addr_i] & (ALLOW_WAW == 0);
        w_sat_hit      = rd_we_i & w_sat[rd_addr_i];
    end

    assign issue_ready_o  = issue_valid_i & w_committed_ok & ~w_raw & ~w_waw & ~w_sat_hit;
    assign stall_raw_o    = issue_valid_i & (w_raw | w_waw | w_sat_hit);
    assign stall_commit_o = issue_valid_i & ~w_committed_ok & ~stall_raw_o;
    assign fwd_sel_o      = w_fwd_sel;
    assign err_o          = err_q;

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            w_inc[r] = issue_ready_o & rd_we_i & (rd_addr_i == AW'(r));
            w_dec[r] = '0;
            for (int w = 0; w < NUM_WB; w++) begin
                if (wb_valid_i[w] && (wb_addr_i[w*AW +: AW] == AW'(r))) begin
                    w_dec[r] = w_dec[r] + c_dec_w'(1);
                end
            end
        end
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
        fpu_ss_pending_cnt #(
            .CNT_WIDTH (CNT_WIDTH),
            .DEC_WIDTH (c_dec_w)
        ) u_cnt (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .inc_i       (w_inc[r]),
            .dec_i       (w_dec[r]),
            .cnt_o       (w_cnt[r]),
            .busy_o      (w_busy[r]),
            .sat_o       (w_sat[r]),
            .underflow_o (w_under[r]),
            .overflow_o  (w_over[r])
        );
    end

    // A commit and a retire of the same ID in one cycle leave the bit set.
    always_comb begin
        commit_d = commit_q;
        for (int i = 0; i < c_num_ids; i++) begin
            if (w_commit_set && (commit_id_i == ID_WIDTH'(i))) begin
                commit_d[i] = 1'b1;
            end else if (retire_valid_i && (retire_id_i == ID_WIDTH'(i))) begin
                commit_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            commit_q <= '0;
            err_q    <= 1'b0;
        end else begin
            commit_q <= commit_d;
            if ((|w_under) | (|w_over)) begin
                err_q <= 1'b1;
            end
        end
    end

`ifdef FPU_SS_HAZARD_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_q <= '0;
        end else if (stall_raw_o | stall_commit_o) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_stall_cnt_o = perf_q;
`else
    assign perf_stall_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpu_ss_hazard_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_fpu_ss_hazard_unit
// Scoreboard bench: two hazard-unit configurations against a pending-count model.
// Rev    : 1.0
// ============================================================================
module tb_fpu_ss_hazard_unit;
    import fpu_ss_pkg::*;

    localparam int NOP  = 3;
    localparam int NWB  = 2;
    localparam int AW   = 5;
    localparam int MAXC = 3;

    typedef struct packed {
        logic            rst;
        logic            v;
        logic [3:0]      id;
        logic [2:0][4:0] rs;
        logic [2:0]      used;
        logic [4:0]      rd;
        logic            we;
        logic            cv;
        logic            ck;
        logic [3:0]      cid;
        logic            rv;
        logic [3:0]      rid;
        logic [1:0]      wbv;
        logic [1:0][4:0] wba;
        logic            chk;
    } stim_t;

    typedef struct packed {
        logic        rdy;
        logic        sraw;
        logic        scmt;
        logic [5:0]  fsel;
        logic        err;
        logic [31:0] perf;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_i = 1'b1;
    logic                 issue_valid_i = 1'b0;
    logic [3:0]           issue_id_i = '0;
    logic [NOP*AW-1:0]    rs_addr_i = '0;
    logic [NOP-1:0]       rs_used_i = '0;
    logic [AW-1:0]        rd_addr_i = '0;
    logic                 rd_we_i = 1'b0;
    logic                 commit_valid_i = 1'b0;
    logic [3:0]           commit_id_i = '0;
    logic                 commit_kill_i = 1'b0;
    logic                 retire_valid_i = 1'b0;
    logic [3:0]           retire_id_i = '0;
    logic [NWB-1:0]       wb_valid_i = '0;
    logic [NWB*AW-1:0]    wb_addr_i = '0;

    logic [1:0]           rdy;
    logic [1:0]           sraw;
    logic [1:0]           scmt;
    logic [1:0]           err;
    logic [1:0][5:0]      fsel;
    logic [1:0][31:0]     perf;

    // dut0: default configuration; dut1: WAW allowed, no forwarding.
    fpu_ss_hazard_unit #(.ALLOW_WAW(0), .FORWARDING(1)) dut0 (
        .clk_i(clk), .rst_i(rst_i), .issue_valid_i(issue_valid_i), .issue_ready_o(rdy[0]),
        .issue_id_i(issue_id_i), .rs_addr_i(rs_addr_i), .rs_used_i(rs_used_i),
        .rd_addr_i(rd_addr_i), .rd_we_i(rd_we_i), .commit_valid_i(commit_valid_i),
        .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
        .retire_valid_i(retire_valid_i), .retire_id_i(retire_id_i),
        .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i), .fwd_sel_o(fsel[0]),
        .stall_raw_o(sraw[0]), .stall_commit_o(scmt[0]), .err_o(err[0]),
        .perf_stall_cnt_o(perf[0])
    );

    fpu_ss_hazard_unit #(.ALLOW_WAW(1), .FORWARDING(0)) dut1 (
        .clk_i(clk), .rst_i(rst_i), .issue_valid_i(issue_valid_i), .issue_ready_o(rdy[1]),
        .issue_id_i(issue_id_i), .rs_addr_i(rs_addr_i), .rs_used_i(rs_used_i),
        .rd_addr_i(rd_addr_i), .rd_we_i(rd_we_i), .commit_valid_i(commit_valid_i),
        .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
        .retire_valid_i(retire_valid_i), .retire_id_i(retire_id_i),
        .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i), .fwd_sel_o(fsel[1]),
        .stall_raw_o(sraw[1]), .stall_commit_o(scmt[1]), .err_o(err[1]),
        .perf_stall_cnt_o(perf[1])
    );

    // Reference state: outstanding writes per register as plain integers.
    int          cnt_m  [2][32];
    bit          cbit   [16];
    bit          err_m  [2];
    logic [31:0] perf_m [2];
    exp_t        q0[$];
    exp_t        q1[$];
    int          checks = 0;
    int          errors = 0;

    function automatic exp_t model_out(int c, stim_t s);
        exp_t e;
        bit   ok, raw, waw, sat, fwd_on, waw_on;
        e      = '0;
        fwd_on = (c == 0);
        waw_on = (c == 1);
        ok     = cbit[s.id] || (s.cv && !s.ck && s.cid == s.id);
        raw    = 1'b0;
        for (int k = 0; k < NOP; k++) begin
            if (s.used[k]) begin
                int src;
                src = -1;
                for (int w = 0; w < NWB; w++)
                    if (src < 0 && s.wbv[w] && s.wba[w] == s.rs[k]) src = w;
                if (fwd_on && src >= 0) e.fsel[k*NWB + src] = 1'b1;
                if (cnt_m[c][s.rs[k]] > 0 && !(fwd_on && cnt_m[c][s.rs[k]] == 1 && src >= 0))
                    raw = 1'b1;
            end
        end
        waw    = s.we && cnt_m[c][s.rd] > 0 && !waw_on;
        sat    = s.we && cnt_m[c][s.rd] == MAXC;
        e.rdy  = s.v && ok && !raw && !waw && !sat;
        e.sraw = s.v && (raw || waw || sat);
        e.scmt = s.v && !ok && !e.sraw;
        e.err  = err_m[c];
`ifdef FPU_SS_HAZARD_PERF_CNT_EN
        e.perf = perf_m[c];
`else
        e.perf = 32'd0;
`endif
        return e;
    endfunction

    function automatic void model_step(int c, stim_t s, exp_t e);
        if (s.rst) begin
            for (int r = 0; r < 32; r++) cnt_m[c][r] = 0;
            err_m[c]  = 1'b0;
            perf_m[c] = 32'd0;
            return;
        end
        for (int r = 0; r < 32; r++) begin
            int n;
            n = cnt_m[c][r];
            if (e.rdy && s.we && int'(s.rd) == r) n++;
            for (int w = 0; w < NWB; w++)
                if (s.wbv[w] && int'(s.wba[w]) == r) n--;
            if (n < 0)    begin n = 0;    err_m[c] = 1'b1; end
            if (n > MAXC) begin n = MAXC; err_m[c] = 1'b1; end
            cnt_m[c][r] = n;
        end
        if (e.sraw || e.scmt) perf_m[c] = perf_m[c] + 32'd1;
    endfunction

    function automatic void commit_step(stim_t s);
        for (int i = 0; i < 16; i++) begin
            if (s.rst)                                         cbit[i] = 1'b0;
            else if (s.cv && !s.ck && int'(s.cid) == i)        cbit[i] = 1'b1;
            else if (s.rv && int'(s.rid) == i)                 cbit[i] = 1'b0;
        end
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s     = '0;
        s.chk = 1'b1;
        return s;
    endfunction

    function automatic logic [4:0] pick_wb();
        int r;
        r = $urandom_range(0, 7);
        if (cnt_m[0][r] == 0 && $urandom_range(0, 3) != 0) r = $urandom_range(0, 7);
        return 5'(r);
    endfunction

    task automatic step(stim_t s);
        exp_t e0, e1;
        @(posedge clk);
        #1;
        rst_i          = s.rst;
        issue_valid_i  = s.v;
        issue_id_i     = s.id;
        rs_addr_i      = s.rs;
        rs_used_i      = s.used;
        rd_addr_i      = s.rd;
        rd_we_i        = s.we;
        commit_valid_i = s.cv;
        commit_id_i    = s.cid;
        commit_kill_i  = s.ck;
        retire_valid_i = s.rv;
        retire_id_i    = s.rid;
        wb_valid_i     = s.wbv;
        wb_addr_i      = s.wba;
        e0 = model_out(0, s);
        e1 = model_out(1, s);
        if (s.chk) begin
            q0.push_back(e0);
            q1.push_back(e1);
        end
        model_step(0, s, e0);
        model_step(1, s, e1);
        commit_step(s);
    endtask

    task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_dut(int c, exp_t e);
        cmp($sformatf("dut%0d issue_ready", c),  32'(rdy[c]),  32'(e.rdy));
        cmp($sformatf("dut%0d stall_raw", c),    32'(sraw[c]), 32'(e.sraw));
        cmp($sformatf("dut%0d stall_commit", c), 32'(scmt[c]), 32'(e.scmt));
        cmp($sformatf("dut%0d fwd_sel", c),      32'(fsel[c]), 32'(e.fsel));
        cmp($sformatf("dut%0d err", c),          32'(err[c]),  32'(e.err));
        cmp($sformatf("dut%0d perf_cnt", c),     perf[c],      e.perf);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin e = q0.pop_front(); check_dut(0, e); end
            if (q1.size() > 0) begin e = q1.pop_front(); check_dut(1, e); end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "bench did not finish");
    end

    initial begin : stimulus
        stim_t s;
        s = '0; s.rst = 1'b1;
        step(s);
        step(s);

        // Reset state, then commit-and-issue in the same cycle.
        s = idle(); step(s);
        s = idle(); s.cv = 1; s.cid = 3; s.v = 1; s.id = 3; s.rd = 5; s.we = 1; step(s);
        s = idle(); s.v = 1; s.id = 3; s.rs[0] = 5; s.used = 3'b001; step(s);
        s = idle(); s.v = 1; s.id = 3; s.rs[1] = 5; s.used = 3'b010;
        s.wbv[WbFpu] = 1'b1; s.wba[WbFpu] = 5; step(s);

        // Repeated writes to one rd: WAW stall vs. saturation.
        for (int i = 0; i < 4; i++) begin
            s = idle(); s.v = 1; s.id = 3; s.rd = 7; s.we = 1; step(s);
        end
        s = idle(); s.wbv = 2'b11; s.wba[WbFpu] = 7; s.wba[WbLsu] = 7; step(s);
        s = idle(); s.v = 1; s.id = 3; s.rs[0] = 7; s.used = 3'b001; step(s);

        // Commit gating: uncommitted, killed, then committed.
        s = idle(); s.v = 1; s.id = 9; step(s);
        s.cv = 1; s.cid = 9; s.ck = 1; step(s);
        s.ck = 0; step(s);

        // Reset with a register pending.
        s = idle(); s.v = 1; s.id = 3; s.rd = 5; s.we = 1; step(s);
        s = idle(); s.rst = 1; step(s);
        s = idle(); s.v = 1; s.id = 3; s.rs[0] = 5; s.used = 3'b001; step(s);
        s = idle(); s.wbv[WbLsu] = 1'b1; s.wba[WbLsu] = 2; step(s);
        s = idle(); step(s);

        for (int n = 0; n < 1500; n++) begin
            s      = idle();
            s.rst  = ($urandom_range(0, 149) == 0);
            s.v    = ($urandom_range(0, 9) < 8);
            s.id   = 4'($urandom_range(0, 3));
            for (int k = 0; k < NOP; k++) s.rs[k] = 5'($urandom_range(0, 7));
            s.used = 3'($urandom);
            s.rd   = 5'($urandom_range(0, 7));
            s.we   = ($urandom_range(0, 9) < 6);
            s.cv   = ($urandom_range(0, 9) < 4);
            s.ck   = ($urandom_range(0, 4) == 0);
            s.cid  = 4'($urandom_range(0, 3));
            s.rv   = ($urandom_range(0, 9) < 3);
            s.rid  = 4'($urandom_range(0, 3));
            for (int w = 0; w < NWB; w++) begin
                s.wbv[w] = ($urandom_range(0, 9) < 3);
                s.wba[w] = pick_wb();
            end
            step(s);
        end

        repeat (3) @(posedge clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", q0.size() + q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
